muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. It executes mult, multu, div and divu for the CPU datapath. It replaces the single-cycle combinational mult/div/mfhi/mflo ALU paths and adds unsigned variants, mthi/mtlo writes and a busy/done handshake that the datapath uses to stall. It sits beside the ALU: the control/alucontrol decode drives start/op, and HI/LO feed the writeback mux.

---
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Handshake and operand bus between the datapath and the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             hiWe;
    logic             loWe;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srcA, srcB, hiWe, loWe, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, srcA, srcB, hiWe, loWe, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Signed ops are run on magnitudes through one unsigned core and fixed up in FIN.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;       // product high half / partial remainder
    logic [WIDTH-1:0] q;         // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] b;         // multiplicand or divisor magnitude
    logic [WIDTH-1:0] a_raw;     // original dividend, returned on divide by zero
    logic             is_div, neg_res, neg_rem, div_zero;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             done_r;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   add_sum, trial;
    logic [WIDTH-1:0] acc_step, q_step;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             accept;

    assign accept   = (state == IDLE) && bus.start;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    // Operand magnitudes; op[0]=0 selects signed interpretation
    always_comb begin
        a_neg = ~bus.op[0] & bus.srcA[WIDTH-1];
        b_neg = ~bus.op[0] & bus.srcB[WIDTH-1];
        a_mag = a_neg ? -bus.srcA : bus.srcA;
        b_mag = b_neg ? -bus.srcB : bus.srcB;
    end

    // One shift-add or restoring shift-subtract step
    always_comb begin
        add_sum  = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
        trial    = {acc, q[WIDTH-1]} - {1'b0, b};
        acc_step = add_sum[WIDTH:1];
        q_step   = {add_sum[0], q[WIDTH-1:1]};
        if (is_div) begin
            if (!trial[WIDTH]) begin
                acc_step = trial[WIDTH-1:0];
                q_step   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {acc[WIDTH-2:0], q[WIDTH-1]};
                q_step   = {q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign fix-up and special cases for the final result
    always_comb begin
        prod     = {acc, q};
        prod_fix = neg_res ? -prod : prod;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (div_zero) begin
            res_hi = a_raw;
            res_lo = '1;
        end else if (is_div) begin
            res_hi = neg_rem ? -acc : acc;
            res_lo = neg_res ? -q : q;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (count == CW'(1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Iteration datapath: load on accept, step while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            acc      <= '0;
            q        <= '0;
            b        <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            count    <= CW'(WIDTH);
            acc      <= '0;
            q        <= a_mag;
            b        <= b_mag;
            a_raw    <= bus.srcA;
            is_div   <= bus.op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= bus.op[1] && (bus.srcB == '0);
            if (!bus.op[1]) begin
                // multiply: q holds the multiplier, b the multiplicand
                q <= b_mag;
                b <= a_mag;
            end
        end else if (state == RUN) begin
            count <= count - CW'(1);
            acc   <= acc_step;
            q     <= q_step;
        end
    end

    // HI/LO: result write on leaving FIN, mthi/mtlo only when idle and not starting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (state == FIN) begin
            hi_r <= res_hi;
            lo_r <= res_lo;
        end else if (state == IDLE && !bus.start) begin
            if (bus.hiWe) hi_r <= bus.wdata;
            if (bus.loWe) lo_r <= bus.wdata;
        end
    end

    // Done pulse in the first idle cycle after FIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_r <= 1'b0;
        else        done_r <= (state == FIN);
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32 and WIDTH=8 instances).
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus ();
    muldiv_if #(.WIDTH(8))  bus8 ();

    muldiv_unit #(.WIDTH(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    muldiv_unit #(.WIDTH(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    // Launch an op (start sampled at edge 0), then follow it to done.
    // Caller is at #1 after a posedge; returns at #1 after the done edge.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic we, output int done_cyc, output logic busy_ok,
                         output logic [31:0] h, output logic [31:0] l);
        bus.start = 1'b1; bus.op = op; bus.srcA = a; bus.srcB = b;
        bus.hiWe = we; bus.loWe = we; bus.wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.hiWe = 1'b0; bus.loWe = 1'b0;
        done_cyc = -1;
        busy_ok  = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            if (bus.done) begin
                done_cyc = c;
                if (bus.busy) busy_ok = 1'b0;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk); #1;
        end
        h = bus.hi;
        l = bus.lo;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.op = 0; bus.srcA = 0; bus.srcB = 0;
        bus.hiWe = 0; bus.loWe = 0; bus.wdata = 0;
        bus8.start = 0; bus8.op = 0; bus8.srcA = 0; bus8.srcB = 0;
        bus8.hiWe = 0; bus8.loWe = 0; bus8.wdata = 0;
        #12;
        tests++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            fails++; $display("FAIL reset_flags: busy/done=%b expected 00", {bus.busy, bus.done});
        end
        tests++;
        if ({bus.hi, bus.lo} !== 64'h0) begin
            fails++; $display("FAIL reset_hilo: got %h expected 0", {bus.hi, bus.lo});
        end
        #8 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        int dc; logic bo; logic [31:0] h, l;
        do_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0, dc, bo, h, l);
        tests++;
        if (dc !== 34 || bo !== 1'b1) begin
            fails++; $display("FAIL mult_latency: done cycle %0d busy_ok %b expected 34/1", dc, bo);
        end
        tests++;
        if ({h, l} !== 64'hFFFFFFFF_FFFFFFF1) begin
            fails++; $display("FAIL mult_signed: got %h expected FFFFFFFFFFFFFFF1", {h, l});
        end
        @(posedge clk); #1;
        tests++;
        if (bus.done !== 1'b0) begin
            fails++; $display("FAIL done_one_cycle: done=%b expected 0", bus.done);
        end
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, dc, bo, h, l);
        tests++;
        if ({h, l} !== 64'hFFFFFFFE_00000001 || dc !== 34) begin
            fails++; $display("FAIL multu: got %h cyc %0d expected FFFFFFFE00000001 cyc 34", {h, l}, dc);
        end
    endtask

    task automatic test_div();
        int dc; logic bo; logic [31:0] h, l;
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, dc, bo, h, l);
        tests++;
        if ({h, l} !== 64'hFFFFFFFF_FFFFFFFD || dc !== 34 || bo !== 1'b1) begin
            fails++; $display("FAIL div_signed: got %h cyc %0d expected FFFFFFFFFFFFFFFD cyc 34", {h, l}, dc);
        end
        do_op(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, dc, bo, h, l);
        tests++;
        if ({h, l} !== 64'h00000001_7FFFFFFC) begin
            fails++; $display("FAIL divu: got %h expected 000000017FFFFFFC", {h, l});
        end
    endtask

    task automatic test_boundaries();
        int dc; logic bo; logic [31:0] h, l;
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, dc, bo, h, l);
        tests++;
        if ({h, l} !== 64'h00000000_80000000) begin
            fails++; $display("FAIL div_overflow: got %h expected 0000000080000000", {h, l});
        end
        do_op(2'b11, 32'h1234, 32'h0, 1'b0, dc, bo, h, l);
        tests++;
        if ({h, l} !== 64'h00001234_FFFFFFFF || dc !== 34) begin
            fails++; $display("FAIL divu_by_zero: got %h cyc %0d expected 00001234FFFFFFFF cyc 34", {h, l}, dc);
        end
        do_op(2'b10, 32'd5, 32'h0, 1'b0, dc, bo, h, l);
        tests++;
        if ({h, l} !== 64'h00000005_FFFFFFFF) begin
            fails++; $display("FAIL div_by_zero: got %h expected 00000005FFFFFFFF", {h, l});
        end
    endtask

    task automatic test_back_to_back();
        int dc; logic bo; logic [31:0] h, l;
        bus.start = 1'b1; bus.op = 2'b00; bus.srcA = 32'd2; bus.srcB = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dc = -1;
        for (int c = 1; c <= 100; c++) begin
            if (c == 10) begin
                bus.start = 1'b1; bus.op = 2'b11; bus.srcA = 32'd9; bus.srcB = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin dc = c; break; end
            @(posedge clk); #1;
        end
        tests++;
        if ({bus.hi, bus.lo} !== 64'h00000000_00000006 || dc !== 34) begin
            fails++; $display("FAIL start_while_busy: got %h cyc %0d expected 6 cyc 34", {bus.hi, bus.lo}, dc);
        end
        // new start in the done cycle
        do_op(2'b11, 32'd9, 32'd3, 1'b0, dc, bo, h, l);
        tests++;
        if ({h, l} !== 64'h00000000_00000003 || dc !== 34 || bo !== 1'b1) begin
            fails++; $display("FAIL start_in_done: got %h cyc %0d busy_ok %b expected 3 cyc 34", {h, l}, dc, bo);
        end
    endtask

    task automatic test_mthi_mtlo();
        int dc;
        bus.hiWe = 1'b1; bus.loWe = 1'b1; bus.wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        bus.hiWe = 1'b0; bus.loWe = 1'b0;
        tests++;
        if ({bus.hi, bus.lo} !== 64'hA5A5A5A5_A5A5A5A5) begin
            fails++; $display("FAIL mthi_mtlo: got %h expected A5A5A5A5A5A5A5A5", {bus.hi, bus.lo});
        end
        // hiWe while busy is ignored
        bus.start = 1'b1; bus.op = 2'b00; bus.srcA = 32'd7; bus.srcB = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c < 5; c++) begin @(posedge clk); #1; end
        bus.hiWe = 1'b1; bus.wdata = 32'h11111111;
        @(posedge clk); #1;
        bus.hiWe = 1'b0;
        tests++;
        if (bus.hi !== 32'hA5A5A5A5) begin
            fails++; $display("FAIL mthi_busy: hi=%h expected A5A5A5A5", bus.hi);
        end
        dc = -1;
        for (int c = 6; c <= 100; c++) begin
            if (bus.done) begin dc = c; break; end
            @(posedge clk); #1;
        end
        tests++;
        if ({bus.hi, bus.lo} !== 64'd49 || dc !== 34) begin
            fails++; $display("FAIL mult_7x7: got %h cyc %0d expected 49 cyc 34", {bus.hi, bus.lo}, dc);
        end
        // write strobes together with start are dropped
        bus.start = 1'b1; bus.op = 2'b00; bus.srcA = 32'd2; bus.srcB = 32'd3;
        bus.hiWe = 1'b1; bus.loWe = 1'b1; bus.wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.hiWe = 1'b0; bus.loWe = 1'b0;
        tests++;
        if ({bus.busy, bus.hi, bus.lo} !== {1'b1, 64'd49}) begin
            fails++; $display("FAIL start_beats_we: busy %b hilo %h expected 1 / 49", bus.busy, {bus.hi, bus.lo});
        end
        dc = -1;
        for (int c = 1; c <= 100; c++) begin
            if (bus.done) begin dc = c; break; end
            @(posedge clk); #1;
        end
        tests++;
        if ({bus.hi, bus.lo} !== 64'd6 || dc !== 34) begin
            fails++; $display("FAIL start_with_we_result: got %h cyc %0d expected 6 cyc 34", {bus.hi, bus.lo}, dc);
        end
    endtask

    task automatic test_reset_mid();
        int dc; int seen; logic bo; logic [31:0] h, l;
        bus.hiWe = 1'b1; bus.wdata = 32'hCAFE0000;
        @(posedge clk); #1;
        bus.hiWe = 1'b0;
        bus.start = 1'b1; bus.op = 2'b00; bus.srcA = 32'h1234; bus.srcB = 32'h10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c < 15; c++) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'h0) begin
            fails++; $display("FAIL reset_mid: busy %b done %b hilo %h expected all 0",
                              bus.busy, bus.done, {bus.hi, bus.lo});
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) seen++;
            @(posedge clk); #1;
        end
        tests++;
        if (seen !== 0 || {bus.hi, bus.lo} !== 64'h0) begin
            fails++; $display("FAIL reset_abort: done pulses %0d hilo %h expected 0 / 0", seen, {bus.hi, bus.lo});
        end
        do_op(2'b00, 32'd7, 32'd7, 1'b0, dc, bo, h, l);
        tests++;
        if ({h, l} !== 64'd49 || dc !== 34) begin
            fails++; $display("FAIL after_reset_mult: got %h cyc %0d expected 49 cyc 34", {h, l}, dc);
        end
    endtask

    task automatic test_width8();
        int dc;
        bus8.start = 1'b1; bus8.op = 2'b00; bus8.srcA = 8'hFF; bus8.srcB = 8'h02;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        dc = -1;
        for (int c = 1; c <= 40; c++) begin
            if (bus8.done) begin dc = c; break; end
            @(posedge clk); #1;
        end
        tests++;
        if ({bus8.hi, bus8.lo} !== 16'hFFFE || dc !== 10) begin
            fails++; $display("FAIL width8_mult: got %h cyc %0d expected FFFE cyc 10", {bus8.hi, bus8.lo}, dc);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_boundaries();
        test_back_to_back();
        test_mthi_mtlo();
        test_reset_mid();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
